// File: rtl/arb_stream_mux.sv
// arb_stream_mux: N-channel valid/ready stream mux, fixed or round-robin select, registered output stage
module arb_stream_mux #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_WIDTH-1:0]      sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_WIDTH-1:0]      out_chan
);
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] gidx;
  logic                 gvalid;
  logic                 load_en;
  logic                 take;
  int                   idx;
  assign load_en = !out_valid || out_ready;
  assign take    = gvalid && load_en && !reset;
  assign in_ready = take ? (CHANNELS'(1) << gidx) : '0;
  // pick the granted channel: sel in fixed mode, first valid at or above rr_ptr (wrapping) in round-robin
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    idx    = 0;
    if (!mode) begin
      gidx   = sel;
      gvalid = (int'(sel) < CHANNELS) ? in_valid[sel] : 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = (int'(rr_ptr) + k) % CHANNELS;
        if (!gvalid && in_valid[idx]) begin
          gvalid = 1'b1;
          gidx   = SEL_WIDTH'(idx);
        end
      end
    end
  end
  // output register loads on a grant, empties when drained with nothing to replace it; pointer advances past rr winners
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      out_valid <= gvalid;
      if (gvalid) begin
        out_data <= in_data[gidx*WIDTH +: WIDTH];
        out_chan <= gidx;
        if (mode) rr_ptr <= (gidx == SEL_WIDTH'(CHANNELS-1)) ? '0 : gidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_arb_stream_mux.sv
// tb_arb_stream_mux: scoreboard bench for the 4-channel, 8-bit stream mux
module tb_arb_stream_mux;
  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
  } beat_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_chan;
  beat_t       q[$];
  logic        m_valid = 1'b0;
  int          m_ptr = 0;
  int          checks = 0;
  int          errors = 0;

  arb_stream_mux #(.WIDTH(8), .CHANNELS(4), .SEL_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant();
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < 4; k++)
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic tick();
    int g;
    logic le;
    logic [3:0] er;
    beat_t b;
    @(negedge clk);
    le = !m_valid || out_ready;
    g = (reset || !le) ? -1 : exp_grant();
    er = (g < 0) ? 4'b0000 : 4'(1 << g);
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
    end
    checks++;
    if (in_ready !== er) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, er, $time);
    end
    if (m_valid && out_ready && !reset) begin
      b = q.pop_front();
      checks++;
      if (out_data !== b.d || out_chan !== b.ch) begin
        errors++;
        $display("FAIL beat: got ch%0d %h expected ch%0d %h at %0t", out_chan, out_data, b.ch, b.d, $time);
      end
    end
    if (reset) begin
      q.delete();
      m_valid = 1'b0;
      m_ptr = 0;
    end else if (le) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        q.push_back('{ch: 2'(g), d: in_data[g*8 +: 8]});
        if (mode) m_ptr = (g + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = '0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode = 1'b1;
    in_valid = 4'b1111;
    in_data = 32'h44332211;
    tick();
    tick();
    reset = 1'b0;
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h c=%0d expected v=0 d=00 c=0", out_valid, out_data, out_chan);
    end
    tick();
  endtask

  task automatic test_fixed();
    mode = 1'b0;
    sel = 2'd2;
    in_data = 32'h00A5005A;
    in_valid = 4'b0101;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 8'hA5 || out_chan !== 2'd2) begin
      errors++;
      $display("FAIL fixed_load: got ch%0d %h expected ch2 a5", out_chan, out_data);
    end
    in_valid = 4'b0001;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fixed_ch0_ignored: got out_valid %b expected 0", out_valid);
    end
    drain();
  endtask

  task automatic test_round_robin();
    mode = 1'b1;
    in_data = 32'h13121110;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'(i % 4) || out_data !== 8'(8'h10 + i % 4)) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got v=%b ch%0d %h expected ch%0d %h", i, out_valid, out_chan, out_data, i % 4, 8'h10 + i % 4);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    mode = 1'b1;
    in_data = 32'h00773C00;
    in_valid = 4'b0010;
    out_ready = 1'b1;
    tick();
    in_valid = 4'b0100;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_data !== 8'h3C || out_chan !== 2'd1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b ch%0d %h expected ch1 3c", i, out_valid, out_chan, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 8'h77 || out_chan !== 2'd2) begin
      errors++;
      $display("FAIL bp_release: got ch%0d %h expected ch2 77", out_chan, out_data);
    end
    drain();
  endtask

  task automatic test_sparse_wrap();
    mode = 1'b1;
    in_data = 32'hD0C0B0A0;
    in_valid = 4'b0010;
    out_ready = 1'b1;
    tick();
    in_valid = 4'b1010;
    tick();
    checks++;
    if (out_chan !== 2'd3 || out_data !== 8'hD0) begin
      errors++;
      $display("FAIL sparse_wrap: got ch%0d %h expected ch3 d0", out_chan, out_data);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    mode = 1'b1;
    in_data = 32'h4433229A;
    in_valid = 4'b0001;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 4'b1111;
    reset = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: got out_valid %b expected 0", out_valid);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_chan !== 2'd0 || out_data !== 8'h9A) begin
      errors++;
      $display("FAIL mid_reset_ptr: got ch%0d %h expected ch0 9a", out_chan, out_data);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
    test_mid_reset();
    drain();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d beats left expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arb_stream_mux.md
# arb_stream_mux

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and on the output, plus a single-entry registered output stage. Selection is either fixed (external `sel`, the direct successor of the 4:1 address-indexed multiplexer) or round-robin arbitration across all requesting channels, chosen at run time by `mode`. It sits between several producers and one consumer wherever a shared datapath (bus, register-file write port, ALU operand) needs flow-controlled channel merging.

## Interface
- `WIDTH`, 8: data bits per channel.
- `CHANNELS`, 4: number of input channels, 2..16.
- `SEL_WIDTH`, 2: width of `sel` and `out_chan`; must equal ceil(log2(CHANNELS)).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `mode` in 1: 0 = fixed select by `sel`, 1 = round-robin.
- `sel` in SEL_WIDTH: channel index used when `mode`=0.
- `in_data` in CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` in CHANNELS: per-channel data-present.
- `in_ready` out CHANNELS: per-channel accept; combinational; at most one bit set.
- `out_data` out WIDTH: registered output data.
- `out_valid` out 1: registered; output register holds a beat.
- `out_ready` in 1: consumer accepts the beat.
- `out_chan` out SEL_WIDTH: registered index of the channel that supplied `out_data`.

## Operation
- Transfer on input i when `in_valid[i]` && `in_ready[i]` at a rising edge; output transfer when `out_valid` && `out_ready`.
- `load_en` = !`out_valid` || `out_ready`. `in_ready[i]` = `grant[i]` && `load_en` && !`reset`.
- Grant, `mode`=0: `grant[sel]` = `in_valid[sel]`. If `sel` >= CHANNELS, no grant. Other channels are never granted, even if valid.
- Grant, `mode`=1: the first channel with `in_valid` set, searching upward from pointer `rr_ptr` with wrap from CHANNELS-1 to 0. No valid channel -> no grant.
- On an input transfer from channel g: `out_data` <= channel g data, `out_chan` <= g, `out_valid` <= 1.
- `load_en` with no grant: `out_valid` <= 0; `out_data` and `out_chan` hold.
- !`load_en` (stalled): all output registers hold; all `in_ready` = 0.
- `rr_ptr`: on a transfer in `mode`=1, `rr_ptr` <= (g+1) mod CHANNELS. It does not change on cycles without a transfer or on transfers in `mode`=0.
- `mode`/`sel` changes affect only the combinational grant in the same cycle. They never disturb a beat already held in the output register.
- Reset (state values on the edge where `reset`=1): `out_valid`=0, `out_data`=0, `out_chan`=0, `rr_ptr`=0. `in_ready` is 0 throughout any cycle with `reset`=1. Reset mid-stream discards the held beat; no input transfer occurs in that cycle.

## Timing
- Latency: a beat accepted at edge N is on `out_data` with `out_valid`=1 immediately after edge N, i.e. visible to the consumer in cycle N+1.
- Throughput: one beat per cycle when `out_ready` stays high. A simultaneous output drain and input load in the same cycle is a replacement, with no bubble.
- Backpressure: with `out_valid`=1 and `out_ready`=0, `out_data`/`out_chan` remain stable until the cycle `out_ready` rises.
- No combinational path from `in_valid`/`in_data` to any output except `in_ready`. `in_ready` depends combinationally on `out_ready`, `mode`, `sel`, `in_valid`, `rr_ptr` and `out_valid`.
- Fairness, `mode`=1: with all CHANNELS continuously valid and `out_ready`=1, grants cycle 0,1,..,CHANNELS-1,0,... Any continuously valid channel is served within CHANNELS transfers.

## Test plan
- Reset check: hold `reset` 2 cycles with all `in_valid`=1 -> `in_ready`=0 throughout; `out_valid`=0, `out_data`=0, `out_chan`=0 after release.
- Fixed mode: `mode`=0, `sel`=2, WIDTH=8, ch2=0xA5 valid, ch0 valid, `out_ready`=1 -> only `in_ready[2]`=1; next cycle `out_data`=0xA5, `out_chan`=2; ch0 is never accepted.
- Round-robin: `mode`=1, all four channels valid with data 0x10,0x11,0x12,0x13, `out_ready`=1 for 8 cycles -> `out_chan` sequence 0,1,2,3,0,1,2,3 with matching data, one beat per cycle.
- Backpressure: load 0x3C from ch1, then `out_ready`=0 for 3 cycles with ch2 valid -> `out_data`=0x3C held, `in_ready`=0; when `out_ready`=1, ch2 is accepted in that same cycle and `out_data` updates on the next edge.
- Sparse round-robin with wrap: `rr_ptr`=3, only ch1 valid -> ch1 granted, `rr_ptr` becomes 2; ch3 and ch1 valid next -> ch3 granted.
- Mid-stream reset: assert `reset` for 1 cycle while `out_valid`=1 and `out_ready`=0 -> `out_valid`=0 after the edge, `rr_ptr`=0, held beat dropped, no input transfer that cycle.
